// File: rtl/nibble_serial_adder.sv
// Word-width adder that reuses one 4-bit CLA, one nibble per clock, LSB nibble first.
// Optional two's-complement overflow output enabled by NIBBLE_SERIAL_ADD_OVF_EN.

module add_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_i,
    output logic [3:0] s,
    output logic       c_o
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Carry lookahead: every carry is a flat sum of products of g/p and c_i
    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
    assign c_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_i);
    assign s    = p ^ c;
endmodule

module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16  // multiple of 4, at least 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [3:0]         nib_a;
    logic [3:0]         nib_b;
    logic [3:0]         nib_s;
    logic               nib_co;

    // Current nibble of the latched operands feeds the shared CLA
    assign nib_a = a_q[{cnt_q, 2'b00} +: 4];
    assign nib_b = b_q[{cnt_q, 2'b00} +: 4];

    add_4bit u_add_4bit (
        .a   (nib_a),
        .b   (nib_b),
        .c_i (carry_q),
        .s   (nib_s),
        .c_o (nib_co)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        c_out_d   = c_out_q;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[{cnt_q, 2'b00} +: 4] = nib_s;
                carry_d = nib_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NIB - 1)) begin
                    cnt_d   = '0;
                    c_out_d = nib_co;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
                    // Top result bit is bit 3 of the final nibble sum
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[3] != a_q[WIDTH-1]);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Handshake flags are registered copies of the next state
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: driver pushes model results, monitor pops on transfer.
// Overflow checks compiled in when NIBBLE_SERIAL_ADD_OVF_EN is defined.

module tb_nibble_serial_adder;
    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    exp_t exp_q[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   rand_bp = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, longint act, longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Reference: plain unsigned arithmetic plus sign-rule overflow
    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci);
        exp_t        e;
        logic [W:0]  t;
        t     = (W+1)'(x) + (W+1)'(y) + (W+1)'(ci);
        e.sum = t[W-1:0];
        e.c   = t[W];
        e.ovf = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return e;
    endfunction

    // Monitor: a transfer happens at the next rising edge when both flags are high
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                pop_cyc.push_back(cyc);
                chk("sum", longint'(sum), longint'(e.sum));
                chk("c_out", longint'(c_out), longint'(e.c));
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
                chk("ovf", longint'(ovf), longint'(e.ovf));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Offer one operand set; returns 1ns after the accepting edge
    task automatic do_op(logic [W-1:0] x, logic [W-1:0] y, logic ci, bit push, bit hold);
        bit done = 0;
        in_valid = 1'b1;
        a = x;
        b = y;
        c_in = ci;
        for (int n = 0; n < 300 && !done; n++) begin
            if (in_ready) begin
                done = 1;
                if (push) exp_q.push_back(model(x, y, ci));
            end
            tick();
        end
        if (!done) chk("accept_timeout", 0, 1);
        if (!hold) begin
            in_valid = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
            c_in = 1'($urandom);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (n < 1000 && !(exp_q.size() == 0 && in_ready && !out_valid)) begin
            tick();
            n++;
        end
        if (!(exp_q.size() == 0 && in_ready && !out_valid)) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        c_in = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_sum", longint'(sum), 0);
        chk("rst_c_out", longint'(c_out), 0);
        rst = 1'b0;
        out_ready = 1'b1;

        // Latency: out_valid appears exactly NIB edges after the accept edge
        do_op(16'h1234, 16'h4321, 1'b0, 1, 0);
        chk("lat_0", longint'(out_valid), 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("lat_%0d", i), longint'(out_valid), (i == 4) ? 1 : 0);
        end
        wait_done();

        // Full carry ripple across all nibbles
        do_op(16'hFFFF, 16'h0001, 1'b0, 1, 0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 1, 0);
        wait_done();

        // Backpressure with a competing in_valid held high
        out_ready = 1'b0;
        do_op(16'h00F0, 16'h0F10, 1'b0, 1, 0);
        in_valid = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        for (int n = 0; n < 20 && !out_valid; n++) begin
            chk("bp_in_ready_run", longint'(in_ready), 0);
            tick();
        end
        chk("bp_out_valid", longint'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", longint'(out_valid), 1);
            chk("bp_hold_sum", longint'(sum), 16'h1000);
            chk("bp_hold_c_out", longint'(c_out), 0);
            chk("bp_hold_in_ready", longint'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_done();

        // Reset on the second RUN cycle aborts the operation
        do_op(16'hAAAA, 16'h5555, 1'b0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", longint'(out_valid), 0);
        chk("abort_in_ready", longint'(in_ready), 1);
        chk("abort_sum", longint'(sum), 0);
        chk("abort_c_out", longint'(c_out), 0);
        do_op(16'h0001, 16'h0001, 1'b0, 1, 0);
        wait_done();

        // Back-to-back with in_valid held: one result every NIB+2 cycles
        begin
            int base;
            base = pop_cyc.size();
            do_op(16'h0102, 16'h0304, 1'b0, 1, 1);
            do_op(16'h8000, 16'h8001, 1'b1, 1, 1);
            do_op(16'h7FFF, 16'h7FFF, 1'b0, 1, 1);
            in_valid = 1'b0;
            wait_done();
            if (pop_cyc.size() >= base + 3) begin
                chk("btb_gap_1", longint'(pop_cyc[base+1] - pop_cyc[base]), 6);
                chk("btb_gap_2", longint'(pop_cyc[base+2] - pop_cyc[base+1]), 6);
            end else begin
                chk("btb_count", longint'(pop_cyc.size() - base), 3);
            end
        end

`ifdef NIBBLE_SERIAL_ADD_OVF_EN
        do_op(16'h7FFF, 16'h0001, 1'b0, 1, 0);
        do_op(16'h8000, 16'h8000, 1'b0, 1, 0);
        do_op(16'h1234, 16'h4321, 1'b0, 1, 0);
        wait_done();
`endif

        // Random operands with random consumer stalls
        rand_bp = 1;
        for (int i = 0; i < 40; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1, 0);
        rand_bp = 0;
        out_ready = 1'b1;
        wait_done();

        chk("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder built on one internal add_4bit carry-lookahead instance. It accepts full-width operands through a valid/ready handshake and feeds the 4-bit adder one nibble per clock, LSB nibble first, holding the ripple carry in a register between nibbles. It returns the full-width sum and carry-out through a second valid/ready handshake. It is the sequencing stage that sits directly upstream of the 4-bit CLA and turns it into a word-width datapath adder.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 8; NIB = WIDTH/4.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry-in for the word
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  A+B+c_in modulo 2^WIDTH
c_out  output  1  carry out of bit WIDTH-1

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst. No other clock or reset.
- Reset values (rst high at a rising edge):
  - state = IDLE; in_ready = 1; out_valid = 0; sum = 0; c_out = 0.
  - Internal operand registers, nibble counter and carry register cleared to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch a, b and c_in into the operand registers and carry register; counter = 0; next state RUN.
- RUN:
  - in_ready = 0; out_valid = 0.
  - Each cycle, present operand nibble [4*cnt+3 : 4*cnt] and the carry register to add_4bit.
  - At the edge: write the 4-bit sum into result bits [4*cnt+3 : 4*cnt], load the carry register from C_o, and increment cnt.
  - When cnt == NIB-1 at the edge: next state DONE and c_out <= C_o.
  - RUN lasts exactly NIB cycles.
- DONE:
  - out_valid = 1; sum and c_out are held stable until the transfer completes.
  - On out_ready: next state IDLE, out_valid = 0. The held sum is kept, not cleared.
  - in_ready = 0 in DONE, so no accept is possible in the cycle a result is consumed.
- Latency: operands accepted at edge k; out_valid is visible after edge k+NIB.
- Throughput: one operation per NIB+2 cycles when out_ready is held high.
- Inputs a, b and c_in may change freely after acceptance; only latched copies are used.
- in_valid in RUN or DONE is ignored. No operand is lost because in_ready is low.
- Arithmetic: pure unsigned modulo 2^WIDTH. The carry chain is exactly the ripple of NIB CLA nibbles.
- Reset during RUN or DONE aborts the operation immediately; the in-flight result is never presented.
- out_valid, in_ready, sum and c_out are registered or decoded from state only; no combinational path from in_valid or out_ready to any output.

Optional Feature:
Macro NIBBLE_SERIAL_ADD_OVF_EN.
- Defined:
  - Extra output port ovf (output, 1): two's-complement overflow of the word.
  - ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]), using the latched operands.
  - Registered with c_out; reset 0; valid only while out_valid = 1.
- Undefined: ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, c_in=0, out_ready=1 -> out_valid exactly 4 cycles after the accept edge; sum=0x5555, c_out=0.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1. Also a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1 (full carry ripple through all 4 nibbles).
- Backpressure: a=0x00F0, b=0x0F10, c_in=0, out_ready=0 for 5 cycles after out_valid -> sum=0x1000, c_out=0, all stable; in_ready=0 throughout; second in_valid ignored until IDLE.
- Reset mid-op: accept a=0xAAAA, b=0x5555; assert rst on the 2nd RUN cycle -> next cycle out_valid=0, in_ready=1, sum=0, c_out=0. A later op a=0x0001, b=0x0001 -> sum=0x0002.
- Back-to-back: in_valid held high with 3 operand sets, out_ready=1 -> results every 6 cycles in order, no drop or duplicate.
- With NIBBLE_SERIAL_ADD_OVF_EN:
  - 0x7FFF+0x0001 -> sum=0x8000, ovf=1, c_out=0.
  - 0x8000+0x8000 -> sum=0x0000, ovf=1, c_out=1.
  - 0x1234+0x4321 -> ovf=0.
